ps2_kbd_ctrl: RTL and testbench

Sequencer that sits between the PS/2 receiver (`ps2_keyboard`) and the keyboard MMIO register slave. It drains the receiver's scan-code FIFO using the `ready`/`nextdata_n` pop handshake and folds `E0`/`F0` prefix bytes into single key events. Events are buffered in a small FIFO and offered through a valid/ready port. When the event FIFO is full, the block stops popping, which applies backpressure into the receiver FIFO.

---
 rtl/ps2_kbd_pkg.sv | 31 +++
 rtl/ps2_kbd_ctrl_if.sv | 21 ++
 rtl/ps2_evt_fifo.sv | 65 ++++++
 rtl/ps2_kbd_ctrl.sv | 139 +++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, event type and pop-FSM state encoding for the PS/2 keyboard sequencer.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ERR_00    = 8'h00;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERR_FF    = 8'hFF;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StSettle
  } pop_state_e;

  // Bytes that are consumed but never become events and leave the prefix flags alone.
  function automatic logic ps2_is_drop(input logic [7:0] b);
    return (b == PS2_PFX_PAUSE) || (b == PS2_ERR_00) || (b == PS2_BAT_OK) ||
           (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Valid/ready key-event stream between the keyboard sequencer and its consumer.
interface ps2_kbd_ctrl_if;
  import ps2_kbd_pkg::*;

  logic     evt_valid;
  logic     evt_ready;
  ps2_evt_t evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous key-event FIFO with extra-MSB pointers and registered head data.
module ps2_evt_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ps2_evt_t wdata,
  input  logic     pop,
  output ps2_evt_t rdata,
  output logic     full,
  output logic     empty,
  output logic     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ps2_evt_t mem_q [DEPTH];
  ptr_t     wptr_q, wptr_d;
  ptr_t     rptr_q, rptr_d;
  ps2_evt_t rdata_q, rdata_d;
  logic     do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = rdata_q;

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & ~do_push;
    wptr_d  = wptr_q + ptr_t'(do_push);
    rptr_d  = rptr_q + ptr_t'(do_pop);
    // Pre-compute the head that will be visible after this edge.
    if (rptr_d == wptr_d) begin
      rdata_d = rdata_q;
    end else if (rptr_d == wptr_q) begin
      rdata_d = wdata;
    end else begin
      rdata_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: drains the receiver FIFO and folds E0/F0 prefixes into key events.
// Optional prefix timeout is built when PS2_KBD_CTRL_TIMEOUT_EN is defined.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned EVT_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kbd_ready,
  input  logic [7:0]            kbd_scan_code,
  input  logic                  kbd_overflow,
  output logic                  kbd_nextdata_n,
  ps2_kbd_ctrl_if.master        evt,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  pop_state_e state_q, state_d;
  logic [7:0] byte_q;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       ovf_q, ovf_d;
  logic       push;
  ps2_evt_t   push_evt;
  ps2_evt_t   head_evt;
  logic       fifo_full, fifo_empty, fifo_drop;
  logic       tmo_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (kbd_ready && !fifo_full) state_d = StPop;
      StPop:    state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    nextdata_n_d = (state_d != StPop);
    ext_d        = ext_q;
    brk_d        = brk_q;
    push         = 1'b0;
    push_evt     = {brk_q, ext_q, byte_q};
    if (state_q == StPop) begin
      if (byte_q == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else if (!ps2_is_drop(byte_q)) begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (tmo_fire) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
    // Set has priority over clear.
    ovf_d = ovf_q;
    if (kbd_overflow || fifo_drop || tmo_fire) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      if (state_q == StIdle && state_d == StPop) begin
        byte_q <= kbd_scan_code;
      end
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      nextdata_n_q <= nextdata_n_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef PS2_KBD_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  // A consumed byte restarts the window, so a pop cycle never times out.
  assign tmo_fire = (ext_q | brk_q) && (state_q != StPop) &&
                    (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StPop || tmo_fire || !(ext_q | brk_q)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign tmo_fire       = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  ps2_evt_fifo #(
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_evt),
    .pop   (evt.evt_valid & evt.evt_ready),
    .rdata (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign kbd_nextdata_n = nextdata_n_q;
  assign evt.evt_valid  = ~fifo_empty;
  assign evt.evt_data   = head_evt;
  assign ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: receiver model, byte-stream decode model, random traffic.
module tb_ps2_kbd_ctrl;
  import ps2_kbd_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_ready = 1'b0;
  logic [7:0] kbd_scan_code = 8'h00;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       ovf_sticky;
  logic       ovf_clr = 1'b0;

  ps2_kbd_ctrl_if evt_if ();

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(
    .EVT_DEPTH (DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_ready      (kbd_ready),
    .kbd_scan_code  (kbd_scan_code),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt            (evt_if.master),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: receiver byte queue, events the DUT must currently hold, delivered events.
  logic [7:0] rx_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] log_q[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       ovf_exp = 1'b0;
  int         tmo_k = 0;
  int         npops = 0;
  int         stall = 0;
  int         since = 100;
  logic       nd_prev = 1'b1;
  logic       rst_prev = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!(b inside {8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
      exp_q.push_back({m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [31:0] logv(input int i);
    if (i < log_q.size()) return {22'd0, log_q[i]};
    return 32'hDEAD;
  endfunction

  // Compare and model-update process; everything here happens on the falling edge.
  always @(negedge clk) begin
    logic fire;
    if (rst_prev) begin
      chk("rst_nextdata_n", kbd_nextdata_n, 1);
      chk("rst_evt_data", evt_if.evt_data, 0);
    end
    chk("evt_valid", evt_if.evt_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("evt_data", evt_if.evt_data, exp_q[0]);
    chk("ovf_sticky", ovf_sticky, ovf_exp);
    chk("nextdata_n_width", nd_prev | kbd_nextdata_n, 1);
    if (!kbd_nextdata_n) begin
      chk("pop_spacing", since >= 3, 1);
      since = 1;
    end else begin
      since++;
    end

    if (rst) begin
      if (!kbd_nextdata_n && rx_q.size() != 0) begin
        void'(rx_q.pop_front());
        npops++;
      end
      exp_q.delete();
      m_ext   = 1'b0;
      m_brk   = 1'b0;
      ovf_exp = 1'b0;
      tmo_k   = 0;
      stall   = 0;
      since   = 100;
    end else begin
      if (evt_if.evt_ready && exp_q.size() != 0) log_q.push_back(exp_q.pop_front());
      fire = 1'b0;
      if (!kbd_nextdata_n) begin
        chk("pop_rx_nonempty", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          model_byte(rx_q.pop_front());
          npops++;
        end
        tmo_k = 0;
      end else if (m_ext || m_brk) begin
        tmo_k++;
`ifdef PS2_KBD_CTRL_TIMEOUT_EN
        if (tmo_k == TMO) begin
          fire  = 1'b1;
          m_ext = 1'b0;
          m_brk = 1'b0;
          tmo_k = 0;
        end
`endif
      end
      if (kbd_overflow || fire) ovf_exp = 1'b1;
      else if (ovf_clr) ovf_exp = 1'b0;
      chk("evt_occupancy", exp_q.size() <= DEPTH, 1);
      if (rx_q.size() != 0 && exp_q.size() < DEPTH && kbd_nextdata_n) stall++;
      else stall = 0;
      chk("pop_progress", stall <= 6, 1);
    end

    kbd_ready     = (rx_q.size() != 0);
    kbd_scan_code = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    nd_prev       = kbd_nextdata_n;
    rst_prev      = rst;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || !kbd_nextdata_n) && t < 300) begin
      cyc(1);
      t++;
    end
    chk("drain_bound", t < 300, 1);
    cyc(3);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] drops [6];
    int r;
    drops = '{8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
    r = $urandom_range(0, 99);
    if (r < 10) return 8'hE0;
    if (r < 20) return 8'hF0;
    if (r < 28) return drops[$urandom_range(0, 5)];
    if (r < 40) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(1, 127));
  endfunction

  int base, p0, lat;

  initial begin
    evt_if.evt_ready = 1'b1;
    rst = 1'b1;
    cyc(3);
    chk("reset_nextdata_n", kbd_nextdata_n, 1);
    chk("reset_evt_valid", evt_if.evt_valid, 0);
    chk("reset_evt_data", evt_if.evt_data, 0);
    chk("reset_ovf", ovf_sticky, 0);
    rst = 1'b0;
    cyc(2);

    // Plain code latency, then a break code.
    base = log_q.size();
    p0   = npops;
    send(8'h1C);
    lat = 0;
    while (!evt_if.evt_valid && lat < 10) begin
      cyc(1);
      lat++;
    end
    chk("latency_plain", lat, 2);
    send(8'hF0);
    send(8'h1C);
    wait_idle();
    chk("t1_count", log_q.size() - base, 2);
    chk("t1_evt0", logv(base), 10'h01C);
    chk("t1_evt1", logv(base + 1), 10'h21C);
    chk("t1_pops", npops - p0, 3);

    // Extended release and press.
    base = log_q.size();
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h75);
    wait_idle();
    chk("t2_count", log_q.size() - base, 2);
    chk("t2_up_release", logv(base), 10'h375);
    chk("t2_up_press", logv(base + 1), 10'h175);

    // Drop bytes: consumed, no events, prefix flags untouched.
    base = log_q.size();
    p0   = npops;
    send(8'hAA); send(8'hFA); send(8'hE1);
    wait_idle();
    chk("t3_no_events", log_q.size() - base, 0);
    chk("t3_pops", npops - p0, 3);
    send(8'h1C);
    send(8'hF0); send(8'hAA); send(8'h1C);
    wait_idle();
    chk("t3_plain", logv(base), 10'h01C);
    chk("t3_brk_kept", logv(base + 1), 10'h21C);

    // Backpressure: FIFO holds 4, receiver keeps 2.
    base = log_q.size();
    evt_if.evt_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    cyc(40);
    chk("t4_rx_left", rx_q.size(), 2);
    chk("t4_held", exp_q.size(), 4);
    chk("t4_valid_held", evt_if.evt_valid, 1);
    evt_if.evt_ready = 1'b1;
    wait_idle();
    chk("t4_count", log_q.size() - base, 6);
    chk("t4_e0", logv(base), 10'h015);
    chk("t4_e1", logv(base + 1), 10'h01D);
    chk("t4_e2", logv(base + 2), 10'h024);
    chk("t4_e3", logv(base + 3), 10'h02D);
    chk("t4_e4", logv(base + 4), 10'h02C);
    chk("t4_e5", logv(base + 5), 10'h035);

    // Overflow flag: set wins over a simultaneous clear.
    kbd_overflow = 1'b1;
    ovf_clr      = 1'b1;
    cyc(1);
    kbd_overflow = 1'b0;
    ovf_clr      = 1'b0;
    cyc(1);
    chk("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
    chk("ovf_cleared", ovf_sticky, 0);

    // Long gap after a break prefix.
    base = log_q.size();
    send(8'hF0);
    wait_idle();
    cyc(20);
    send(8'h1C);
    wait_idle();
`ifdef PS2_KBD_CTRL_TIMEOUT_EN
    chk("t5_timeout_evt", logv(base), 10'h01C);
    chk("t5_timeout_ovf", ovf_sticky, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
    chk("t5_ovf_clr", ovf_sticky, 0);
`else
    chk("t5_persist_evt", logv(base), 10'h21C);
    chk("t5_no_ovf", ovf_sticky, 0);
`endif

    // Reset in the settle cycle after a break prefix.
    base = log_q.size();
    send(8'hF0);
    lat = 0;
    while (kbd_nextdata_n && lat < 20) begin
      cyc(1);
      lat++;
    end
    chk("t6_pop_seen", lat < 20, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_nextdata_n", kbd_nextdata_n, 1);
    chk("t6_rst_valid", evt_if.evt_valid, 0);
    chk("t6_rst_data", evt_if.evt_data, 0);
    chk("t6_rst_ovf", ovf_sticky, 0);
    rst = 1'b0;
    cyc(2);
    send(8'h1C);
    wait_idle();
    chk("t6_count", log_q.size() - base, 1);
    chk("t6_no_brk", logv(base), 10'h01C);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if (rx_q.size() < 6 && $urandom_range(0, 99) < 35) send(rand_byte());
      evt_if.evt_ready = ($urandom_range(0, 99) < 70);
      kbd_overflow     = ($urandom_range(0, 99) < 2);
      ovf_clr          = ($urandom_range(0, 99) < 5);
      rst              = ($urandom_range(0, 999) < 5);
      cyc(1);
    end
    rst              = 1'b0;
    kbd_overflow     = 1'b0;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
